// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the ld/st port.
// Data normally wins. After MAX_DATA_RUN data grants in a row while fetch waits,
// fetch gets the port. Read returns one cycle after acceptance are routed back
// to whichever side issued them.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_f_rd,
  input  logic [15:0] i_f_addr,
  output logic        o_f_stall,
  output logic        o_f_rdvalid,
  output logic [15:0] o_f_rddata,
  input  logic        i_d_rd,
  input  logic        i_d_wr,
  input  logic [15:0] i_d_addr,
  input  logic [15:0] i_d_wrdata,
  output logic        o_d_stall,
  output logic        o_d_rdvalid,
  output logic [15:0] o_d_rddata,
  input  logic        i_flush,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic        i_mem_waitrequest,
  input  logic [15:0] i_mem_rddata
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  // active_q stays low through reset and the cycle it is released in, so
  // requests are ignored until the first edge after deassertion.
  logic       active_q, active_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  tag_e       tag_q, tag_d;

  logic f_req;
  logic d_req;
  logic fetch_gnt;
  logic data_gnt;
  logic accepted;

  // Request qualification and grant decision
  always_comb begin
    f_req     = i_f_rd & ~i_flush;
    d_req     = i_d_rd | i_d_wr;
    fetch_gnt = active_q & f_req & (~d_req | (run_cnt_q == MAX_RUN));
    data_gnt  = active_q & d_req & ~fetch_gnt;
    accepted  = ~i_mem_waitrequest;
  end

  // Drive the memory bus from the winner; a store takes priority over a load
  always_comb begin
    o_mem_addr   = 16'h0000;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = 16'h0000;
    if (fetch_gnt) begin
      o_mem_addr = i_f_addr & 16'hFFFE;
      o_mem_rd   = 1'b1;
    end else if (data_gnt) begin
      o_mem_addr = i_d_addr & 16'hFFFE;
      o_mem_rd   = ~i_d_wr;
      o_mem_wr   = i_d_wr;
      if (i_d_wr) begin
        o_mem_wrdata = i_d_wrdata;
      end
    end
  end

  // Stalls and return routing. The fetch stall looks at the raw request so a
  // fetch held during a flush is told to keep holding it.
  always_comb begin
    o_f_stall   = active_q & i_f_rd & ~(fetch_gnt & accepted);
    o_d_stall   = active_q & d_req & ~(data_gnt & accepted);
    o_f_rdvalid = (tag_q == TAG_FETCH) & ~i_flush;
    o_d_rdvalid = (tag_q == TAG_DATA);
    o_f_rddata  = o_f_rdvalid ? i_mem_rddata : 16'h0000;
    o_d_rddata  = o_d_rdvalid ? i_mem_rddata : 16'h0000;
  end

  // Next-state for the fairness counter and the outstanding-read tag
  always_comb begin
    active_d  = 1'b1;
    run_cnt_d = run_cnt_q;
    tag_d     = TAG_NONE;
    if (!f_req || (fetch_gnt && accepted)) begin
      run_cnt_d = 4'd0;
    end else if (data_gnt && accepted && (run_cnt_q != MAX_RUN)) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
    if (accepted && fetch_gnt && !i_flush) begin
      tag_d = TAG_FETCH;
    end else if (accepted && data_gnt && !i_d_wr) begin
      tag_d = TAG_DATA;
    end
  end

  // State registers; reset discards any pending read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      run_cnt_q <= 4'd0;
      tag_q     <= TAG_NONE;
    end else begin
      active_q  <= active_d;
      run_cnt_q <= run_cnt_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized plus directed bench for mem_port_arbiter, checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_f_rd = 1'b0;
  logic [15:0] i_f_addr = 16'h0;
  logic        o_f_stall, o_f_rdvalid;
  logic [15:0] o_f_rddata;
  logic        i_d_rd = 1'b0, i_d_wr = 1'b0;
  logic [15:0] i_d_addr = 16'h0, i_d_wrdata = 16'h0;
  logic        o_d_stall, o_d_rdvalid;
  logic [15:0] o_d_rddata;
  logic        i_flush = 1'b0;
  logic [15:0] o_mem_addr, o_mem_wrdata;
  logic        o_mem_rd, o_mem_wr;
  logic        i_mem_waitrequest = 1'b0;
  logic [15:0] i_mem_rddata = 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: whether the arbiter is out of reset, how many data accesses
  // have beaten a waiting fetch, and which side owns the next read return.
  bit m_active = 1'b0;
  int m_run = 0;
  int m_owner = 0;  // 0 none, 1 fetch, 2 data

  mem_port_arbiter #(.MAX_DATA_RUN(MAXR)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_f_rd(i_f_rd), .i_f_addr(i_f_addr), .o_f_stall(o_f_stall),
    .o_f_rdvalid(o_f_rdvalid), .o_f_rddata(o_f_rddata),
    .i_d_rd(i_d_rd), .i_d_wr(i_d_wr), .i_d_addr(i_d_addr), .i_d_wrdata(i_d_wrdata),
    .o_d_stall(o_d_stall), .o_d_rdvalid(o_d_rdvalid), .o_d_rddata(o_d_rddata),
    .i_flush(i_flush), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_mem_wrdata(o_mem_wrdata),
    .i_mem_waitrequest(i_mem_waitrequest), .i_mem_rddata(i_mem_rddata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check shortly after, advance model, wait posedge
  task automatic step(input bit frd, input logic [15:0] fa, input bit drd, input bit dwr,
                      input logic [15:0] da, input logic [15:0] dwd, input bit fl, input bit wq);
    bit freq, dreq, acc, e_rd, e_wr, e_fst, e_dst, e_frv, e_drv;
    int who;
    logic [15:0] e_addr;
    @(negedge clk);
    i_f_rd = frd; i_f_addr = fa; i_d_rd = drd; i_d_wr = dwr;
    i_d_addr = da; i_d_wrdata = dwd; i_flush = fl; i_mem_waitrequest = wq;
    i_mem_rddata = 16'($urandom);
    #1;
    freq = frd && !fl;
    dreq = drd || dwr;
    who = 0;
    if (m_active) begin
      if (dreq && !(freq && m_run >= MAXR)) who = 2;
      else if (freq) who = 1;
    end
    acc    = (who != 0) && !wq;
    e_addr = (who == 1) ? (fa & 16'hFFFE) : (who == 2) ? (da & 16'hFFFE) : 16'h0;
    e_rd   = (who == 1) || (who == 2 && !dwr);
    e_wr   = (who == 2) && dwr;
    e_fst  = m_active && frd && !(who == 1 && acc);
    e_dst  = m_active && dreq && !(who == 2 && acc);
    e_frv  = (m_owner == 1) && !fl;
    e_drv  = (m_owner == 2);
    check("mem_addr", o_mem_addr, e_addr);
    check("mem_rd", 16'(o_mem_rd), 16'(e_rd));
    check("mem_wr", 16'(o_mem_wr), 16'(e_wr));
    if (e_wr) check("mem_wrdata", o_mem_wrdata, dwd);
    check("f_stall", 16'(o_f_stall), 16'(e_fst));
    check("d_stall", 16'(o_d_stall), 16'(e_dst));
    check("f_rdvalid", 16'(o_f_rdvalid), 16'(e_frv));
    check("d_rdvalid", 16'(o_d_rdvalid), 16'(e_drv));
    check("f_rddata", o_f_rddata, e_frv ? i_mem_rddata : 16'h0);
    check("d_rddata", o_d_rddata, e_drv ? i_mem_rddata : 16'h0);
    $display("cyc t=%0t who=%0d acc=%0d addr=%h fst=%0d dst=%0d frv=%0d drv=%0d",
             $time, who, acc, o_mem_addr, o_f_stall, o_d_stall, o_f_rdvalid, o_d_rdvalid);
    if (!reset_n) begin
      m_active = 1'b0; m_run = 0; m_owner = 0;
    end else begin
      if (!freq || (who == 1 && acc)) m_run = 0;
      else if (who == 2 && acc && m_run < MAXR) m_run = m_run + 1;
      m_owner = (acc && e_rd) ? who : 0;
      m_active = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    // Reset held with every request high: everything must stay quiet
    repeat (2) step(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check("rst_mem_rd", 16'(o_mem_rd), 16'h0);
    #2 reset_n = 1'b1;
    idle();
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    idle();

    // Contention: load wins first, fetch next cycle
    step(1'b1, 16'h0100, 1'b1, 1'b0, 16'h2003, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    idle();

    // Fairness: continuous loads with a held fetch
    for (int i = 0; i < 7; i++)
      step(1'b1, 16'h0200, 1'b1, 1'b0, 16'(16'h4000 + 2 * i), 16'h0, 1'b0, 1'b0);
    idle();

    // Back-pressure on a store
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000, 16'hBEEF, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000, 16'hBEEF, 1'b0, 1'b0);
    idle();

    // Flush after an accepted fetch, then flush while a load return lands
    step(1'b1, 16'h0300, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0302, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h5000, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0304, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();

    // Randomized traffic, with bursts of forced contention
    for (int i = 0; i < 1500; i++) begin
      bit burst;
      burst = ((i / 40) % 3) == 1;
      step($urandom_range(0, 9) < 7, 16'($urandom),
           burst ? 1'b1 : 1'($urandom), $urandom_range(0, 3) == 0, 16'($urandom),
           16'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset pulsed between an accepted load and its return edge
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h6000, 16'h0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_d_rdvalid", 16'(o_d_rdvalid), 16'h0);
    check("midrst_mem_rd", 16'(o_mem_rd), 16'h0);
    m_active = 1'b0; m_run = 0; m_owner = 0;
    #1 reset_n = 1'b1;
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h6000, 16'h0, 1'b0, 1'b0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
